// File: rtl/aes_cmd_sequencer_if.sv
// Command/result bundle between the execute stage, the AES command sequencer
// and the AES core.
interface aes_cmd_sequencer_if #(
  parameter int DATA_W  = 16,
  parameter int BLOCK_W = 128
);
  logic               cmd_valid_i;
  logic [1:0]         cmd_op_i;
  logic               cmd_sel_i;
  logic [DATA_W-1:0]  cmd_wdata_i;
  logic               stall_o;
  logic [DATA_W-1:0]  rdata_o;
  logic               rdata_valid_o;
  logic               err_o;
  logic               aes_start_o;
  logic [BLOCK_W-1:0] aes_key_o;
  logic [BLOCK_W-1:0] aes_data_o;
  logic               aes_done_i;
  logic [BLOCK_W-1:0] aes_result_i;
  logic               busy_o;
  logic               result_ready_o;

  // Pipeline/AES-core side: issues commands, returns the core's completion.
  modport master (
    output cmd_valid_i, cmd_op_i, cmd_sel_i, cmd_wdata_i, aes_done_i, aes_result_i,
    input  stall_o, rdata_o, rdata_valid_o, err_o, aes_start_o, aes_key_o,
           aes_data_o, busy_o, result_ready_o
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_sel_i, cmd_wdata_i, aes_done_i, aes_result_i,
    output stall_o, rdata_o, rdata_valid_o, err_o, aes_start_o, aes_key_o,
           aes_data_o, busy_o, result_ready_o
  );
endinterface

// File: rtl/aes_cmd_sequencer.sv
// AES command sequencer: packs FILL words into key/data blocks, launches the
// core on ISSUE, stalls while it runs, and returns the result word by word on FETCH.
module aes_cmd_sequencer #(
  parameter int DATA_W  = 16,
  parameter int BLOCK_W = 128
) (
  input logic                clk,
  input logic                reset,
  aes_cmd_sequencer_if.slave bus
);
  localparam int NWORDS = BLOCK_W / DATA_W;
  localparam int PW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  localparam logic [1:0] OP_FILL  = 2'b01;
  localparam logic [1:0] OP_ISSUE = 2'b10;
  localparam logic [1:0] OP_FETCH = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] key_word_reg  [NWORDS];
  logic [DATA_W-1:0] data_word_reg [NWORDS];
  logic [DATA_W-1:0] res_word_reg  [NWORDS];
  logic [PW-1:0]     key_ptr_reg, data_ptr_reg, fetch_ptr_reg;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              rdata_valid_reg, rdata_valid_next;
  logic              err_reg, err_next;
  logic              start_reg, start_next;

  logic cmd_active, stall, accept;
  logic do_fill, do_issue, do_fetch, fill_key, fill_data, capture;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NWORDS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign cmd_active = bus.cmd_valid_i && (bus.cmd_op_i != 2'b00);
  // Every AES command is held off while the core runs, even in the done cycle.
  assign stall      = cmd_active && (state_reg == RUN);
  assign accept     = cmd_active && !stall;
  assign do_fill    = accept && (bus.cmd_op_i == OP_FILL);
  assign do_issue   = accept && (bus.cmd_op_i == OP_ISSUE);
  assign do_fetch   = accept && (bus.cmd_op_i == OP_FETCH);
  assign fill_key   = do_fill && bus.cmd_sel_i;
  assign fill_data  = do_fill && !bus.cmd_sel_i;
  assign capture    = (state_reg == RUN) && bus.aes_done_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      rdata_reg       <= '0;
      rdata_valid_reg <= 1'b0;
      err_reg         <= 1'b0;
      start_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      rdata_reg       <= rdata_next;
      rdata_valid_reg <= rdata_valid_next;
      err_reg         <= err_next;
      start_reg       <= start_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    rdata_next       = rdata_reg;
    rdata_valid_next = 1'b0;
    err_next         = 1'b0;
    start_next       = do_issue;
    case (state_reg)
      IDLE: begin
        if (do_issue) state_next = RUN;
        if (do_fetch) begin
          rdata_next       = '0;
          rdata_valid_next = 1'b1;
          err_next         = 1'b1;
        end
      end
      RUN: begin
        if (bus.aes_done_i) state_next = DONE;
      end
      DONE: begin
        if (do_issue) state_next = RUN;
        if (do_fetch) begin
          rdata_next       = res_word_reg[fetch_ptr_reg];
          rdata_valid_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_ptr_reg   <= '0;
      data_ptr_reg  <= '0;
      fetch_ptr_reg <= '0;
    end else if (do_issue) begin
      key_ptr_reg   <= '0;
      data_ptr_reg  <= '0;
      fetch_ptr_reg <= '0;
    end else begin
      if (fill_key)  key_ptr_reg  <= ptr_inc(key_ptr_reg);
      if (fill_data) data_ptr_reg <= ptr_inc(data_ptr_reg);
      if (do_fetch && state_reg == DONE) fetch_ptr_reg <= ptr_inc(fetch_ptr_reg);
    end
  end

  // Word 0 occupies the least significant DATA_W bits of each block.
  for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word
    always_ff @(posedge clk) begin
      if (reset) begin
        key_word_reg[gi]  <= '0;
        data_word_reg[gi] <= '0;
        res_word_reg[gi]  <= '0;
      end else begin
        if (fill_key && key_ptr_reg == PW'(gi))   key_word_reg[gi]  <= bus.cmd_wdata_i;
        if (fill_data && data_ptr_reg == PW'(gi)) data_word_reg[gi] <= bus.cmd_wdata_i;
        if (capture) res_word_reg[gi] <= bus.aes_result_i[gi*DATA_W +: DATA_W];
      end
    end
    assign bus.aes_key_o[gi*DATA_W +: DATA_W]  = key_word_reg[gi];
    assign bus.aes_data_o[gi*DATA_W +: DATA_W] = data_word_reg[gi];
  end

  assign bus.stall_o        = stall;
  assign bus.rdata_o        = rdata_reg;
  assign bus.rdata_valid_o  = rdata_valid_reg;
  assign bus.err_o          = err_reg;
  assign bus.aes_start_o    = start_reg;
  assign bus.busy_o         = (state_reg == RUN);
  assign bus.result_ready_o = (state_reg == DONE);
endmodule

// File: tb/tb_aes_cmd_sequencer.sv
// Directed bench for aes_cmd_sequencer: fill, issue/stall, fetch, wrap, idle
// errors and reset during a run, all against hand-computed values.
module tb_aes_cmd_sequencer;
  localparam int DW = 16;
  localparam int BW = 128;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  aes_cmd_sequencer_if #(.DATA_W(DW), .BLOCK_W(BW)) bus ();

  aes_cmd_sequencer #(.DATA_W(DW), .BLOCK_W(BW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic sel,
                       input logic [DW-1:0] wd);
    bus.cmd_valid_i = v;
    bus.cmd_op_i    = op;
    bus.cmd_sel_i   = sel;
    bus.cmd_wdata_i = wd;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.aes_done_i   = 1'b0;
    bus.aes_result_i = '0;
    drive(1'b1, 2'b01, 1'b0, 16'hDEAD);
    tick;
    tick;
    reset = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 16'h0000);
    #1;
    $display("reset: key=%h data=%h busy=%b ready=%b", bus.aes_key_o, bus.aes_data_o,
             bus.busy_o, bus.result_ready_o);
    n_cmp++; if (bus.aes_key_o !== 128'h0) begin n_err++; $display("FAIL reset_key: got %h want 0", bus.aes_key_o); end
    n_cmp++; if (bus.aes_data_o !== 128'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", bus.aes_data_o); end
    n_cmp++; if (bus.rdata_o !== 16'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", bus.rdata_o); end
    n_cmp++; if ({bus.rdata_valid_o, bus.err_o, bus.aes_start_o} !== 3'b000) begin n_err++; $display("FAIL reset_pulses: got %b want 000", {bus.rdata_valid_o, bus.err_o, bus.aes_start_o}); end
    n_cmp++; if ({bus.busy_o, bus.result_ready_o, bus.stall_o} !== 3'b000) begin n_err++; $display("FAIL reset_state: got %b want 000", {bus.busy_o, bus.result_ready_o, bus.stall_o}); end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'b01, 1'b1, 16'(i + 1));
      #1;
      n_cmp++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL fill_key_stall: got %b want 0", bus.stall_o); end
      tick;
      $display("fill key word %0d = %h", i, 16'(i + 1));
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'b01, 1'b0, 16'((i + 1) * 16'h1111));
      #1;
      n_cmp++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL fill_data_stall: got %b want 0", bus.stall_o); end
      tick;
      $display("fill data word %0d = %h", i, 16'((i + 1) * 16'h1111));
    end
    drive(1'b0, 2'b00, 1'b0, 16'h0000);
    n_cmp++; if (bus.aes_key_o !== 128'h0008_0007_0006_0005_0004_0003_0002_0001) begin n_err++; $display("FAIL fill_key: got %h want 0008..0001", bus.aes_key_o); end
    n_cmp++; if (bus.aes_data_o !== 128'h8888_7777_6666_5555_4444_3333_2222_1111) begin n_err++; $display("FAIL fill_data: got %h want 8888..1111", bus.aes_data_o); end
  endtask

  task automatic test_issue_run;
    drive(1'b1, 2'b10, 1'b0, 16'h0000);
    tick;
    drive(1'b0, 2'b00, 1'b0, 16'h0000);
    $display("issue: start=%b busy=%b", bus.aes_start_o, bus.busy_o);
    n_cmp++; if (bus.aes_start_o !== 1'b1) begin n_err++; $display("FAIL issue_start: got %b want 1", bus.aes_start_o); end
    n_cmp++; if (bus.busy_o !== 1'b1) begin n_err++; $display("FAIL issue_busy: got %b want 1", bus.busy_o); end
    tick;
    n_cmp++; if (bus.aes_start_o !== 1'b0) begin n_err++; $display("FAIL issue_start_once: got %b want 0", bus.aes_start_o); end
    drive(1'b1, 2'b11, 1'b0, 16'h0000);
    for (int k = 0; k < 9; k++) begin
      #1;
      n_cmp++; if (bus.stall_o !== 1'b1) begin n_err++; $display("FAIL run_stall[%0d]: got %b want 1", k, bus.stall_o); end
      n_cmp++; if (bus.aes_key_o !== 128'h0008_0007_0006_0005_0004_0003_0002_0001) begin n_err++; $display("FAIL run_key_hold[%0d]: got %h", k, bus.aes_key_o); end
      if (k == 8) begin
        bus.aes_done_i   = 1'b1;
        bus.aes_result_i = 128'h000F_000E_000D_000C_000B_000A_0009_0008;
      end
      tick;
    end
    bus.aes_done_i = 1'b0;
    $display("done: ready=%b busy=%b stall=%b", bus.result_ready_o, bus.busy_o, bus.stall_o);
    n_cmp++; if ({bus.result_ready_o, bus.busy_o} !== 2'b10) begin n_err++; $display("FAIL done_state: got %b want 10", {bus.result_ready_o, bus.busy_o}); end
    n_cmp++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL done_stall: got %b want 0", bus.stall_o); end
    n_cmp++; if (bus.rdata_valid_o !== 1'b0) begin n_err++; $display("FAIL stalled_fetch_early: got %b want 0", bus.rdata_valid_o); end
    tick;
    drive(1'b0, 2'b00, 1'b0, 16'h0000);
    $display("fetch after stall: rdata=%h valid=%b", bus.rdata_o, bus.rdata_valid_o);
    n_cmp++; if (bus.rdata_o !== 16'h0008) begin n_err++; $display("FAIL first_fetch: got %h want 0008", bus.rdata_o); end
    n_cmp++; if ({bus.rdata_valid_o, bus.err_o} !== 2'b10) begin n_err++; $display("FAIL first_fetch_flags: got %b want 10", {bus.rdata_valid_o, bus.err_o}); end
    tick;
    n_cmp++; if (bus.rdata_valid_o !== 1'b0) begin n_err++; $display("FAIL first_fetch_pulse: got %b want 0", bus.rdata_valid_o); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_words [9] = '{16'h0009, 16'h000A, 16'h000B, 16'h000C, 16'h000D,
                                   16'h000E, 16'h000F, 16'h0008, 16'h0009};
    drive(1'b1, 2'b11, 1'b0, 16'h0000);
    for (int j = 0; j < 9; j++) begin
      tick;
      $display("fetch %0d: rdata=%h valid=%b", j, bus.rdata_o, bus.rdata_valid_o);
      n_cmp++; if (bus.rdata_o !== exp_words[j]) begin n_err++; $display("FAIL b2b_rdata[%0d]: got %h want %h", j, bus.rdata_o, exp_words[j]); end
      n_cmp++; if ({bus.rdata_valid_o, bus.result_ready_o} !== 2'b11) begin n_err++; $display("FAIL b2b_flags[%0d]: got %b want 11", j, {bus.rdata_valid_o, bus.result_ready_o}); end
    end
    drive(1'b0, 2'b00, 1'b0, 16'h0000);
    tick;
    n_cmp++; if ({bus.rdata_valid_o, bus.result_ready_o} !== 2'b01) begin n_err++; $display("FAIL b2b_end: got %b want 01", {bus.rdata_valid_o, bus.result_ready_o}); end
  endtask

  task automatic test_idle_fetch;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    drive(1'b1, 2'b11, 1'b0, 16'h0000);
    tick;
    drive(1'b0, 2'b00, 1'b0, 16'h0000);
    $display("idle fetch: rdata=%h valid=%b err=%b", bus.rdata_o, bus.rdata_valid_o, bus.err_o);
    n_cmp++; if (bus.rdata_o !== 16'h0000) begin n_err++; $display("FAIL idle_rdata: got %h want 0000", bus.rdata_o); end
    n_cmp++; if ({bus.rdata_valid_o, bus.err_o} !== 2'b11) begin n_err++; $display("FAIL idle_flags: got %b want 11", {bus.rdata_valid_o, bus.err_o}); end
    n_cmp++; if ({bus.busy_o, bus.result_ready_o} !== 2'b00) begin n_err++; $display("FAIL idle_state: got %b want 00", {bus.busy_o, bus.result_ready_o}); end
    tick;
    n_cmp++; if ({bus.rdata_valid_o, bus.err_o} !== 2'b00) begin n_err++; $display("FAIL idle_flags_pulse: got %b want 00", {bus.rdata_valid_o, bus.err_o}); end
    bus.aes_done_i   = 1'b1;
    bus.aes_result_i = {8{16'hFFFF}};
    tick;
    bus.aes_done_i = 1'b0;
    $display("stray done in idle: ready=%b busy=%b", bus.result_ready_o, bus.busy_o);
    n_cmp++; if ({bus.busy_o, bus.result_ready_o} !== 2'b00) begin n_err++; $display("FAIL idle_done_ignored: got %b want 00", {bus.busy_o, bus.result_ready_o}); end
  endtask

  task automatic test_fill_wrap;
    drive(1'b1, 2'b01, 1'b1, 16'h1234);
    tick;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 2'b01, 1'b0, 16'(16'hA000 + i));
      tick;
      $display("fill data (wrap) %0d = %h", i, 16'(16'hA000 + i));
    end
    drive(1'b0, 2'b00, 1'b0, 16'h0000);
    n_cmp++; if (bus.aes_data_o !== 128'hA007_A006_A005_A004_A003_A002_A001_A008) begin n_err++; $display("FAIL wrap_data: got %h want A007..A001_A008", bus.aes_data_o); end
    n_cmp++; if (bus.aes_key_o !== 128'h0000_0000_0000_0000_0000_0000_0000_1234) begin n_err++; $display("FAIL wrap_key: got %h want ..1234", bus.aes_key_o); end
  endtask

  task automatic test_reset_mid_run;
    drive(1'b1, 2'b10, 1'b0, 16'h0000);
    tick;
    drive(1'b0, 2'b00, 1'b0, 16'h0000);
    n_cmp++; if (bus.busy_o !== 1'b1) begin n_err++; $display("FAIL midrun_busy: got %b want 1", bus.busy_o); end
    reset = 1'b1;
    drive(1'b1, 2'b01, 1'b0, 16'h5555);
    tick;
    reset = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 16'h0000);
    $display("reset mid-run: busy=%b ready=%b data=%h", bus.busy_o, bus.result_ready_o, bus.aes_data_o);
    n_cmp++; if ({bus.busy_o, bus.result_ready_o, bus.aes_start_o} !== 3'b000) begin n_err++; $display("FAIL midrun_reset_state: got %b want 000", {bus.busy_o, bus.result_ready_o, bus.aes_start_o}); end
    n_cmp++; if (bus.aes_data_o !== 128'h0) begin n_err++; $display("FAIL midrun_reset_cmd_dropped: got %h want 0", bus.aes_data_o); end
    bus.aes_done_i   = 1'b1;
    bus.aes_result_i = 128'hFFFF;
    tick;
    bus.aes_done_i = 1'b0;
    n_cmp++; if ({bus.busy_o, bus.result_ready_o} !== 2'b00) begin n_err++; $display("FAIL midrun_late_done: got %b want 00", {bus.busy_o, bus.result_ready_o}); end
    drive(1'b1, 2'b10, 1'b0, 16'h0000);
    tick;
    drive(1'b0, 2'b00, 1'b0, 16'h0000);
    $display("reissue: start=%b busy=%b", bus.aes_start_o, bus.busy_o);
    n_cmp++; if ({bus.aes_start_o, bus.busy_o} !== 2'b11) begin n_err++; $display("FAIL reissue: got %b want 11", {bus.aes_start_o, bus.busy_o}); end
    bus.aes_done_i   = 1'b1;
    bus.aes_result_i = 128'h0001;
    tick;
    bus.aes_done_i = 1'b0;
    n_cmp++; if ({bus.result_ready_o, bus.busy_o} !== 2'b10) begin n_err++; $display("FAIL reissue_done: got %b want 10", {bus.result_ready_o, bus.busy_o}); end
    drive(1'b1, 2'b11, 1'b0, 16'h0000);
    tick;
    drive(1'b0, 2'b00, 1'b0, 16'h0000);
    $display("fetch after reissue: rdata=%h valid=%b", bus.rdata_o, bus.rdata_valid_o);
    n_cmp++; if (bus.rdata_o !== 16'h0001) begin n_err++; $display("FAIL reissue_fetch: got %h want 0001", bus.rdata_o); end
    n_cmp++; if ({bus.rdata_valid_o, bus.err_o} !== 2'b10) begin n_err++; $display("FAIL reissue_fetch_flags: got %b want 10", {bus.rdata_valid_o, bus.err_o}); end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_issue_run;
    test_back_to_back;
    test_idle_fetch;
    test_fill_wrap;
    test_reset_mid_run;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
